// File: rtl/dmem_copy_engine.sv
// Data-memory copy engine: moves a block of 32-bit words from a source to a
// destination address through the shared memory port and keeps an XOR checksum.
module dmem_copy_engine #(
   parameter int LEN_W  = 9,
   parameter int ADDR_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic [ADDR_W-1:0] src_addr_i,
   input  logic [ADDR_W-1:0] dst_addr_i,
   input  logic [LEN_W-1:0]  len_i,
   output logic              mem_re_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   input  logic [31:0]       mem_rdata_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [LEN_W-1:0]  words_done_o,
   output logic [31:0]       checksum_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);
   localparam logic [LEN_W-1:0]  LEN_ZERO  = {LEN_W{1'b0}};
   localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] src_q, src_d;
   logic [ADDR_W-1:0] dst_q, dst_d;
   logic [LEN_W-1:0]  rem_q, rem_d;
   logic [LEN_W-1:0]  words_q, words_d;
   logic [31:0]       buf_q, buf_d;
   logic [31:0]       csum_q, csum_d;

   logic              re_q, re_d;
   logic              we_q, we_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;

   function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
      return {a[ADDR_W-1:2], 2'b00};
   endfunction

   // Transfer sequencing: next state, pointers, counters and checksum.
   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      rem_d   = rem_q;
      words_d = words_q;
      buf_d   = buf_q;
      csum_d  = csum_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               src_d   = word_align(src_addr_i);
               dst_d   = word_align(dst_addr_i);
               rem_d   = len_i;
               words_d = LEN_ZERO;
               csum_d  = 32'h0000_0000;
               if (len_i != LEN_ZERO) begin
                  state_d = ST_READ;
               end else begin
                  state_d = ST_DONE;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_READ: begin
            buf_d  = mem_rdata_i;
            csum_d = csum_q ^ mem_rdata_i;
            src_d  = src_q + WORD_STEP;
            if (abort_i) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            dst_d   = dst_q + WORD_STEP;
            words_d = words_q + LEN_ONE;
            rem_d   = rem_q - LEN_ONE;
            if (abort_i) begin
               state_d = ST_IDLE;
            end else if (rem_q == LEN_ONE) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_READ;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Port outputs are decoded from the upcoming state so they come straight from flops.
   always_comb begin
      re_d    = 1'b0;
      we_d    = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      addr_d  = {ADDR_W{1'b0}};
      wdata_d = 32'h0000_0000;
      case (state_d)
         ST_READ: begin
            re_d   = 1'b1;
            busy_d = 1'b1;
            addr_d = src_d;
         end
         ST_WRITE: begin
            we_d    = 1'b1;
            busy_d  = 1'b1;
            addr_d  = dst_d;
            wdata_d = buf_d;
         end
         ST_DONE: begin
            done_d = 1'b1;
            busy_d = 1'b1;
         end
         default: begin
            re_d = 1'b0;
         end
      endcase
   end

   // State, datapath and output registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         src_q   <= {ADDR_W{1'b0}};
         dst_q   <= {ADDR_W{1'b0}};
         rem_q   <= LEN_ZERO;
         words_q <= LEN_ZERO;
         buf_q   <= 32'h0000_0000;
         csum_q  <= 32'h0000_0000;
         re_q    <= 1'b0;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         addr_q  <= {ADDR_W{1'b0}};
         wdata_q <= 32'h0000_0000;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         rem_q   <= rem_d;
         words_q <= words_d;
         buf_q   <= buf_d;
         csum_q  <= csum_d;
         re_q    <= re_d;
         we_q    <= we_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign mem_re_o     = re_q;
   assign mem_we_o     = we_q;
   assign mem_addr_o   = addr_q;
   assign mem_wdata_o  = wdata_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign words_done_o = words_q;
   assign checksum_o   = csum_q;

endmodule

// File: tb/tb_dmem_copy_engine.sv
// Bench for dmem_copy_engine: a 1024-word memory beside the engine and a
// word-by-word reference copy model that predicts memory, checksum and timing.
module tb_dmem_copy_engine;

   localparam int MEM_WORDS = 1024;
   localparam logic [31:0] PI_WORDS [4] = '{32'h3243f6a8, 32'h885a308d, 32'h313198a2, 32'he0370734};

   logic        clk = 1'b0;
   logic        rst_n, start, abort;
   logic [31:0] src_addr, dst_addr;
   logic [8:0]  len;
   logic        mem_re, mem_we, busy, done;
   logic [31:0] mem_addr, mem_wdata, mem_rdata, checksum;
   logic [8:0]  words_done;

   logic [31:0] mem      [MEM_WORDS];
   logic [31:0] init_img [MEM_WORDS];
   logic [31:0] ref_mem  [MEM_WORDS];
   logic        mem_init;

   int checks   = 0;
   int failures = 0;

   dmem_copy_engine #(.LEN_W(9), .ADDR_W(32)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .start_i      (start),
      .abort_i      (abort),
      .src_addr_i   (src_addr),
      .dst_addr_i   (dst_addr),
      .len_i        (len),
      .mem_re_o     (mem_re),
      .mem_we_o     (mem_we),
      .mem_addr_o   (mem_addr),
      .mem_wdata_o  (mem_wdata),
      .mem_rdata_i  (mem_rdata),
      .busy_o       (busy),
      .done_o       (done),
      .words_done_o (words_done),
      .checksum_o   (checksum)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr[11:2]];

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < MEM_WORDS; i++) mem[i] <= init_img[i];
      end else if (mem_we) begin
         mem[mem_addr[11:2]] <= mem_wdata;
      end
   end

   function automatic int widx(input logic [31:0] a);
      return int'((a >> 2) % 32'd1024);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic init_memory();
      for (int i = 0; i < MEM_WORDS; i++) begin
         init_img[i] = (i < 4) ? PI_WORDS[i] : $urandom;
         ref_mem[i]  = init_img[i];
      end
      @(negedge clk) mem_init = 1'b1;
      @(negedge clk) mem_init = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".re"}, 32'(mem_re), 32'd0);
      check({tag, ".we"}, 32'(mem_we), 32'd0);
      check({tag, ".addr"}, mem_addr, 32'd0);
      check({tag, ".wdata"}, mem_wdata, 32'd0);
      check({tag, ".busy"}, 32'(busy), 32'd0);
      check({tag, ".done"}, 32'(done), 32'd0);
      check({tag, ".words"}, 32'(words_done), 32'd0);
      check({tag, ".csum"}, checksum, 32'd0);
   endtask

   // kind: 0 full copy, 1 abort at write #at, 2 abort at read #at, 3 reset during read #at
   task automatic run_copy(input string tag, input logic [31:0] s, input logic [31:0] d,
                           input int n, input int kind, input int at, input bit restart);
      logic [31:0] exp_words[$];
      logic [31:0] exp_cs, sa, da, w;
      int n_rd, n_wr, k, rd, wr, busy_cyc, done_cyc, done_cnt, bad_cyc, both, bad_mem;
      bit finished;
      sa = s & 32'hFFFF_FFFC;
      da = d & 32'hFFFF_FFFC;
      n_rd = (kind == 0) ? n : at;
      n_wr = (kind == 0) ? n : ((kind == 1) ? at : at - 1);
      exp_cs = 32'd0;
      for (int i = 0; i < n_rd; i++) begin
         w = ref_mem[widx(sa + 32'(4 * i))];
         exp_cs ^= w;
         if (i < n_wr) begin
            ref_mem[widx(da + 32'(4 * i))] = w;
            exp_words.push_back(w);
         end
      end

      @(negedge clk);
      start = 1'b1; src_addr = s; dst_addr = d; len = n[8:0];
      @(posedge clk);
      k = 0; rd = 0; wr = 0; busy_cyc = 0; done_cyc = -1; done_cnt = 0; bad_cyc = 0; both = 0;
      finished = 1'b0;
      while (!finished && k < 2 * n + 8) begin
         @(negedge clk);
         k++;
         start = 1'b0;
         abort = 1'b0;
         if (restart && k == 1) begin
            start = 1'b1; src_addr = 32'h0000_0800; dst_addr = 32'h0000_0900; len = 9'd5;
         end
         if (busy) busy_cyc++;
         else finished = 1'b1;
         if (done) begin
            done_cnt++;
            done_cyc = k;
         end
         if (mem_re && mem_we) both++;
         if (mem_re) begin
            if (mem_addr !== sa + 32'(4 * rd)) bad_cyc++;
            rd++;
            if (kind == 2 && rd == at) abort = 1'b1;
            if (kind == 3 && rd == at) begin
               rst_n = 1'b0;
               #1;
               check_all_zero({tag, ".rst"});
               finished = 1'b1;
            end
         end
         if (mem_we) begin
            if (wr >= exp_words.size() || mem_addr !== da + 32'(4 * wr) || mem_wdata !== exp_words[wr])
               bad_cyc++;
            wr++;
            if (kind == 1 && wr == at) abort = 1'b1;
         end
      end
      abort = 1'b0;
      check({tag, ".ended"}, 32'(finished), 32'd1);
      check({tag, ".reads"}, 32'(rd), 32'(n_rd));
      check({tag, ".writes"}, 32'(wr), 32'(n_wr));
      check({tag, ".bus_trace"}, 32'(bad_cyc), 32'd0);
      check({tag, ".re_we_both"}, 32'(both), 32'd0);
      if (kind == 3) begin
         @(negedge clk) rst_n = 1'b1;
         @(negedge clk);
         check_all_zero({tag, ".after_rst"});
      end else begin
         check({tag, ".done_cnt"}, 32'(done_cnt), (kind == 0) ? 32'd1 : 32'd0);
         if (kind == 0) check({tag, ".done_cyc"}, 32'(done_cyc), 32'(2 * n + 1));
         check({tag, ".busy_cyc"}, 32'(busy_cyc),
               (kind == 0) ? 32'(2 * n + 1) : ((kind == 1) ? 32'(2 * at) : 32'(2 * at - 1)));
         check({tag, ".words_done"}, 32'(words_done), 32'(n_wr % 512));
         check({tag, ".checksum"}, checksum, exp_cs);
      end
      bad_mem = 0;
      for (int i = 0; i < MEM_WORDS; i++) if (mem[i] !== ref_mem[i]) bad_mem++;
      check({tag, ".mem"}, 32'(bad_mem), 32'd0);
   endtask

   initial begin
      int n, kind, at;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; mem_init = 1'b0;
      src_addr = 32'd0; dst_addr = 32'd0; len = 9'd0;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      init_memory();
      run_copy("copy4", 32'h000, 32'h200, 4, 0, 0, 1'b0);
      check("copy4.w128", mem[128], 32'h3243f6a8);
      check("copy4.w129", mem[129], 32'h885a308d);
      check("copy4.w130", mem[130], 32'h313198a2);
      check("copy4.w131", mem[131], 32'he0370734);
      check("copy4.csum_const", checksum, 32'h6b1f59b3);

      init_memory();
      run_copy("zero_len", 32'h040, 32'h300, 0, 0, 0, 1'b0);

      init_memory();
      run_copy("misalign", 32'h003, 32'h103, 1, 0, 0, 1'b1);
      check("misalign.w64", mem[64], 32'h3243f6a8);

      init_memory();
      run_copy("abort_wr", 32'h000, 32'h200, 8, 1, 2, 1'b0);

      init_memory();
      run_copy("reset_rd", 32'h000, 32'h200, 8, 3, 3, 1'b0);
      run_copy("after_rst", 32'h010, 32'h280, 1, 0, 0, 1'b0);

      init_memory();
      run_copy("overlap", 32'h000, 32'h004, 3, 0, 0, 1'b0);
      check("overlap.w3", mem[3], 32'h3243f6a8);

      run_copy("abort_rd", 32'h100, 32'h180, 5, 2, 3, 1'b0);
      run_copy("wrap", 32'hFFFF_FFF8, 32'hFFFF_FFFC, 4, 0, 0, 1'b0);
      run_copy("long", $urandom, $urandom, 300, 0, 0, 1'b0);

      for (int r = 0; r < 8; r++) begin
         n    = $urandom_range(1, 40);
         kind = $urandom_range(0, 2);
         at   = $urandom_range(1, n);
         run_copy($sformatf("rand%0d", r), $urandom, $urandom, n, kind, at, r[0]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
